// File: rtl/key_press_if.sv
// Bundle between the pushbutton front end and the rhythm-pattern checker:
// the raw key in, and the debounced level and classified press events out.
interface key_press_if #(
    parameter int CNT_W = 32
);
    logic             key;
    logic             key_down;
    logic             press_valid;
    logic             press_long;
    logic [CNT_W-1:0] press_cycles;
    logic             idle_pulse;

    modport master (
        output key,
        input  key_down, press_valid, press_long, press_cycles, idle_pulse
    );

    modport slave (
        input  key,
        output key_down, press_valid, press_long, press_cycles, idle_pulse
    );
endinterface

// File: rtl/key_press_classifier.sv
// Synchronizes and debounces an active-low pushbutton, measures each press,
// classifies it as short or long, and flags long released silences.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RELEASED | key_db high; idle timer runs once a press has completed
// PRESSED  | key_db low; dur counts debounced low cycles
module key_press_classifier #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int LONG_CYCLES     = 25_000_000,
    parameter int IDLE_CYCLES     = 100_000_000,
    parameter int CNT_W           = 32
) (
    input logic        clk,
    input logic        rst,
    key_press_if.slave bus
);
    localparam int               DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [63:0]      LONG_MIN  = 64'(LONG_CYCLES);
    localparam logic [63:0]      IDLE_LAST = 64'(IDLE_CYCLES) - 64'd1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {RELEASED, PRESSED} state_t;

    logic             sync1, sync2, key_db, key_down_r;
    logic [DB_W-1:0]  db_cnt;
    state_t           state;
    logic [CNT_W-1:0] dur, idle_cnt, press_cycles_r;
    logic             idle_armed, press_valid_r, press_long_r, idle_pulse_r;

    // key_down is loaded alongside key_db so it never lags the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            key_db     <= 1'b1;
            key_down_r <= 1'b0;
            db_cnt     <= '0;
        end else begin
            sync1 <= bus.key;
            sync2 <= sync1;
            if (sync2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db     <= sync2;
                key_down_r <= ~sync2;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RELEASED;
            dur            <= '0;
            idle_cnt       <= '0;
            idle_armed     <= 1'b0;
            press_valid_r  <= 1'b0;
            press_long_r   <= 1'b0;
            press_cycles_r <= '0;
            idle_pulse_r   <= 1'b0;
        end else begin
            press_valid_r <= 1'b0;
            idle_pulse_r  <= 1'b0;
            case (state)
                RELEASED: begin
                    if (!key_db) begin
                        state      <= PRESSED;
                        dur        <= CNT_W'(1);
                        idle_cnt   <= '0;
                        idle_armed <= 1'b0;
                    end else if (idle_armed) begin
                        if (64'(idle_cnt) == IDLE_LAST) begin
                            idle_pulse_r <= 1'b1;
                            idle_armed   <= 1'b0;
                        end else if (idle_cnt != CNT_MAX) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (key_db) begin
                        state          <= RELEASED;
                        press_valid_r  <= 1'b1;
                        press_cycles_r <= dur;
                        press_long_r   <= (64'(dur) >= LONG_MIN);
                        idle_armed     <= 1'b1;
                        idle_cnt       <= '0;
                    end else if (dur != CNT_MAX) begin
                        dur <= dur + 1'b1;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

    assign bus.key_down     = key_down_r;
    assign bus.press_valid  = press_valid_r;
    assign bus.press_long   = press_long_r;
    assign bus.press_cycles = press_cycles_r;
    assign bus.idle_pulse   = idle_pulse_r;
endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Upstream front end for the rhythm-pattern checker: takes the raw active-low pushbutton, synchronizes and debounces it, and measures each press.
- Emits one classified event per completed press: short or long, against the same 0.5 s threshold used by the checker, plus the measured duration.
- Emits an idle pulse after a long silence so the downstream pattern FSM can abandon a half-entered sequence.

Parameters:
- DEBOUNCE_CYCLES, 500_000, consecutive cycles a new raw level must hold before it is accepted (10 ms at 50 MHz).
- LONG_CYCLES, 25_000_000, press duration at or above which a press is long.
- IDLE_CYCLES, 100_000_000, released cycles after a press before idle_pulse fires.
- CNT_W, 32, width of the duration and idle counters; both saturate.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- key  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk
- key_down  output  1  debounced level, active-high (1 = pressed)
- press_valid  output  1  one-cycle strobe on completion of a press
- press_long  output  1  class of last press (1 = long); held until the next strobe
- press_cycles  output  CNT_W  duration of last press in cycles; held until the next strobe
- idle_pulse  output  1  one-cycle strobe after IDLE_CYCLES released cycles

Behaviour:
- Reset (async, active-high):
  - Sync flops = 1; key_db = 1 (released); debounce counter = 0.
  - State = RELEASED; dur = 0; idle counter = 0; idle_armed = 0.
  - Outputs: key_down = 0, press_valid = 0, press_long = 0, press_cycles = 0, idle_pulse = 0.
- Synchronizer: two flops on key; no logic on the first flop.
- Debounce:
  - If sync output equals key_db, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still disagreeing, key_db takes the sync value on that edge and the counter clears.
  - Any agreeing cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES never change key_db.
- key_down = ~key_db, registered.
- FSM, evaluated on key_db:
  - RELEASED, key_db = 0: go to PRESSED; dur <= 1; idle counter <= 0; idle_armed <= 0.
  - PRESSED, key_db = 0: dur <= dur + 1, saturating at 2^CNT_W-1.
  - PRESSED, key_db = 1: go to RELEASED; press_valid <= 1 for exactly one cycle; press_cycles <= dur; press_long <= (dur >= LONG_CYCLES); idle_armed <= 1; idle counter <= 0.
- Duration rule: press_cycles equals the number of cycles key_db was 0 (debounced width), compared without truncation.
- Latency:
  - key_db follows a stable raw edge by 2 + DEBOUNCE_CYCLES cycles.
  - press_valid rises one cycle after key_db returns to 1.
- Idle timer:
  - Counts only in RELEASED with idle_armed = 1.
  - When the count reaches IDLE_CYCLES-1: idle_pulse for one cycle, then idle_armed <= 0.
  - Exactly one pulse per release gap.
  - No pulse after reset until a press has completed.
- Simultaneous events: press_valid and idle_pulse can never assert in the same cycle. A new press cancels a pending idle count.
- Reset mid-press: the interrupted press produces no press_valid. If the key is still held after reset, it is treated as a new press once debounced.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, IDLE_CYCLES=50, CNT_W=8):
1. key low for 10 cycles, then high -> exactly one press_valid, press_long=0, press_cycles=10; key_down high for 10 cycles, delayed 6 cycles from the raw edge.
2. Boundary presses of 19, 20, and 30 cycles -> press_long = 0, 1, 1; press_cycles = 19, 20, 30.
3. Bounce: raw pulses of 3 cycles low / 1 cycle high, repeated 10 times, then steady high -> key_down stays 0, no press_valid.
4. Saturation: key held 300 cycles -> press_cycles=255, press_long=1, single press_valid.
5. rst asserted 5 cycles into a 15-cycle press, key released during reset -> no press_valid; all outputs 0 through and after reset.
6. Idle: after a completed press, 60 released cycles -> single idle_pulse 50 cycles after press_valid, none after. Reset alone followed by 200 idle cycles -> no idle_pulse.
